key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter N_KEYS, default 4: number of independent key channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: stable-input cycles required before the debounced state changes (20 ms at 50 MHz); legal range 2 to 2^24.
REQ-003 Parameter CNT_W, default 24: counter width; SHALL satisfy 2^CNT_W >= DEBOUNCE_CYCLES.
REQ-004 clk  input  1  system clock (CLOCK_50 domain); sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 key_n  input  N_KEYS  raw push-button inputs; active-low (0 = pressed); asynchronous to clk.
REQ-007 key_level  output  N_KEYS  debounced key state; active-high (1 = pressed); registered.
REQ-008 key_press  output  N_KEYS  one-cycle pulse per channel on each debounced press; registered.
REQ-009 key_release  output  N_KEYS  one-cycle pulse per channel on each debounced release; registered.

Function
REQ-010 Each channel SHALL pass key_n through a two-flop synchronizer before any other logic uses it.
REQ-011 Each channel SHALL be fully independent; activity on one channel SHALL NOT affect another's counter or outputs.
REQ-012 Each channel SHALL hold a stable state, exposed on key_level, and a counter of CNT_W bits.
REQ-013 When the synchronized value (inverted to active-high) equals the stable state, the counter SHALL clear to 0 on that edge.
REQ-014 When the synchronized value differs from the stable state and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-015 When the synchronized value differs and the counter equals DEBOUNCE_CYCLES-1, the stable state SHALL take the synchronized value and the counter SHALL clear to 0 on that same edge.
REQ-016 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-017 Latency: a clean input step captured at edge 1 SHALL change key_level at edge DEBOUNCE_CYCLES+2.
REQ-018 Glitch rule: any return to the stable value before the count completes SHALL clear the counter, so a bounce of up to DEBOUNCE_CYCLES-1 synchronized cycles SHALL produce no output change.
REQ-019 key_press SHALL be 1 for exactly the cycle following the edge where key_level goes 0->1, and 0 otherwise.
REQ-020 key_release SHALL be 1 for exactly the cycle following the edge where key_level goes 1->0, and 0 otherwise.
REQ-021 key_press and key_release SHALL never be 1 simultaneously on the same channel.
REQ-022 Simultaneous transitions on multiple channels SHALL each produce their own pulse in the same cycle.
REQ-023 A held key SHALL produce exactly one key_press, with no auto-repeat.

Reset
REQ-024 On reset assertion, all state SHALL clear immediately, independent of clk.
REQ-025 Reset values: synchronizer flops = 1 (released), stable state = 0, counters = 0, key_level = 0, key_press = 0, key_release = 0.
REQ-026 Reset mid-count SHALL discard the partial count.
REQ-027 A key held through reset deassertion SHALL be debounced afresh and produce key_press after DEBOUNCE_CYCLES+2 cycles.

Verification (DEBOUNCE_CYCLES = 8, N_KEYS = 4)
REQ-028 Bench SHALL cover: key_n[0] driven 1->0 and held -> key_level[0] rises at edge 10; key_press[0] high for one cycle after it; other bits stay 0.
REQ-029 Bench SHALL cover: key_n[1] bounce of 0 for 5 cycles, 1 for 2 cycles, then 0 held -> no output change during the bounce; key_level[1] rises 10 edges after the final falling edge.
REQ-030 Bench SHALL cover: pressed key_n[2] released (0->1) and held -> key_level[2] falls at edge 10; key_release[2] pulses once; no key_press.
REQ-031 Bench SHALL cover: all four keys pressed on the same cycle -> key_level = 4'b1111 and key_press = 4'b1111 for exactly one cycle, simultaneously.
REQ-032 Bench SHALL cover: reset asserted at count 5 with key_n[3] = 0 -> outputs 0 immediately; after release, key_press[3] pulses 10 edges after the first post-reset edge.
REQ-033 Bench SHALL cover: key_n[0] held low for 1000 cycles -> exactly one key_press[0] pulse and key_level[0] = 1 throughout after latency.

Source files
------------

// File: rtl/key_debounce.sv
// key_debounce: per-channel two-flop synchronizer, stable-count debouncer and
// registered press/release pulse generator for active-low push buttons.
module key_debounce #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [N_KEYS-1:0] sync1_q, sync2_q, level_q, level_d, press_q, press_d, release_q, release_d;
  logic [N_KEYS-1:0] differ, done;
  logic [N_KEYS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    differ = ~sync2_q ^ level_q;
    done = '0;
    cnt_d = cnt_q;
    for (int i = 0; i < N_KEYS; i++) begin
      done[i] = differ[i] && cnt_q[i] == LAST;
      cnt_d[i] = (differ[i] && !done[i]) ? cnt_q[i] + 1'b1 : '0;
    end
    level_d = level_q ^ done;
    press_d = level_d & ~level_q;
    release_d = ~level_d & level_q;
  end
  // Synchronizer resets to released so a key held through reset is debounced afresh.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      level_q <= '0;
      press_q <= '0;
      release_q <= '0;
      cnt_q <= '0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      release_q <= release_d;
      cnt_q <= cnt_d;
    end
  end
  assign key_level = level_q;
  assign key_press = press_q;
  assign key_release = release_q;
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed edge-accurate scenarios plus random key activity,
// checked every cycle against a sliding-window reference model.
module tb_key_debounce;
  localparam int N = 4;
  localparam int DC = 8;
  logic clk = 0, reset = 1;
  logic [N-1:0] key_n = '1;
  logic [N-1:0] key_level, key_press, key_release;
  int n_checks = 0, n_fail = 0;

  key_debounce #(.N_KEYS(N), .DEBOUNCE_CYCLES(DC), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .key_n(key_n),
    .key_level(key_level), .key_press(key_press), .key_release(key_release)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Model: a channel flips when the last DC synchronized samples (taken two
  // edges late) all disagree with its level; pre-reset history reads released.
  logic [N-1:0] hist[$];
  logic [N-1:0] m_level = '0, m_press = '0, m_release = '0, same;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist.delete();
      for (int k = 0; k < DC + 1; k++) hist.push_back('1);
      m_level <= '0;
      m_press <= '0;
      m_release <= '0;
    end else begin
      same = '1;
      for (int k = 0; k < DC; k++) same &= ~(hist[k] ^ m_level);
      m_press <= same & ~m_level;
      m_release <= same & m_level;
      m_level <= m_level ^ same;
      hist.push_back(key_n);
      void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin
    check("model_level", 32'(key_level), 32'(m_level));
    check("model_press", 32'(key_press), 32'(m_press));
    check("model_release", 32'(key_release), 32'(m_release));
    check("press_and_release", 32'(key_press & key_release), 32'd0);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    #1;
    check("reset_level", 32'(key_level), 32'd0);
    check("reset_press", 32'(key_press), 32'd0);
    cyc(2);
    reset = 0;
  endtask

  int presses, bad;
  int hold[N];

  initial begin
    cyc(2);
    do_reset();
    key_n = 4'b1111;
    cyc(3);
    // Clean press on key 0
    key_n = 4'b1110;
    cyc(9);
    check("s1_level_e9", 32'(key_level), 32'b0000);
    cyc(1);
    check("s1_level_e10", 32'(key_level), 32'b0001);
    check("s1_press_e10", 32'(key_press), 32'b0001);
    cyc(1);
    check("s1_press_e11", 32'(key_press), 32'b0000);
    // Bounce on key 1
    key_n = 4'b1100;
    cyc(5);
    key_n = 4'b1110;
    cyc(2);
    check("s2_bounce_level", 32'(key_level), 32'b0001);
    key_n = 4'b1100;
    cyc(9);
    check("s2_level_e9", 32'(key_level), 32'b0001);
    cyc(1);
    check("s2_level_e10", 32'(key_level), 32'b0011);
    check("s2_press_e10", 32'(key_press), 32'b0010);
    // Press then release key 2
    key_n = 4'b1000;
    cyc(12);
    check("s3_pressed", 32'(key_level), 32'b0111);
    key_n = 4'b1100;
    cyc(9);
    check("s3_level_e9", 32'(key_level), 32'b0111);
    cyc(1);
    check("s3_level_e10", 32'(key_level), 32'b0011);
    check("s3_release_e10", 32'(key_release), 32'b0100);
    check("s3_press_e10", 32'(key_press), 32'b0000);
    cyc(1);
    check("s3_release_e11", 32'(key_release), 32'b0000);
    // All four simultaneously
    do_reset();
    key_n = 4'b1111;
    cyc(2);
    key_n = 4'b0000;
    cyc(9);
    check("s4_level_e9", 32'(key_level), 32'b0000);
    cyc(1);
    check("s4_level_e10", 32'(key_level), 32'b1111);
    check("s4_press_e10", 32'(key_press), 32'b1111);
    cyc(1);
    check("s4_press_e11", 32'(key_press), 32'b0000);
    // Reset mid-count on key 3 while others are held
    key_n = 4'b1000;
    cyc(12);
    check("s5_pre_level", 32'(key_level), 32'b0111);
    key_n = 4'b0000;
    cyc(7);
    #1 reset = 1;
    #1;
    check("s5_async_level", 32'(key_level), 32'b0000);
    check("s5_async_press", 32'(key_press), 32'b0000);
    check("s5_async_release", 32'(key_release), 32'b0000);
    @(posedge clk);
    #1 reset = 0;
    cyc(9);
    check("s5_level_e9", 32'(key_level), 32'b0000);
    cyc(1);
    check("s5_press_e10", 32'(key_press), 32'b1111);
    // Long hold: one press, level stays
    do_reset();
    key_n = 4'b1110;
    presses = 0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc(1);
      presses += int'(key_press[0]);
      if (i >= 9 && !key_level[0]) bad++;
    end
    check("s6_press_count", 32'(presses), 32'd1);
    check("s6_level_drops", 32'(bad), 32'd0);
    // Random bouncing and holding, checked by the model
    do_reset();
    for (int k = 0; k < N; k++) hold[k] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < N; k++) begin
        if (hold[k] == 0) begin
          key_n[k] = 1'($urandom_range(0, 1));
          hold[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(DC, 3 * DC)) : int'($urandom_range(1, DC));
        end
        hold[k]--;
      end
      if (i == 1500) begin
        reset = 1;
        cyc(1);
        reset = 0;
      end
      cyc(1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
